yazma_tamponu: RTL and testbench

//  Write-back buffer between the cache (onbellek) and main memory (anabellek).

---
 rtl/yazma_tamponu.sv | 220 ++++++++++++++++++++++
 tb/tb_yazma_tamponu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yazma_tamponu.sv
// Write-back buffer between the cache (onbellek) and main memory (anabellek).
// Dirty-line evictions are parked in a small circular FIFO and drained to
// memory in acceptance order. Reads that hit a buffered line are answered
// locally; misses are forwarded to memory. One FSM owns the memory port.
module yazma_tamponu #(
    parameter int DERINLIK = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [31:0]                   ob_istek_adres_i,
    input  logic [255:0]                  ob_istek_veri_i,
    input  logic                          ob_istek_gecerli_i,
    input  logic                          ob_istek_yaz_gecerli_i,
    output logic                          ob_istek_hazir_o,
    output logic [255:0]                  ob_yanit_veri_o,
    output logic                          ob_yanit_gecerli_o,
    input  logic                          ob_yanit_hazir_i,
    output logic [31:0]                   ab_istek_adres_o,
    output logic [255:0]                  ab_istek_veri_o,
    output logic                          ab_istek_gecerli_o,
    output logic                          ab_istek_yaz_gecerli_o,
    input  logic                          ab_istek_hazir_i,
    input  logic [255:0]                  ab_yanit_veri_i,
    input  logic                          ab_yanit_gecerli_i,
    output logic                          ab_yanit_hazir_o,
    output logic [$clog2(DERINLIK):0]     doluluk_o
);

    localparam int PW = $clog2(DERINLIK);
    localparam int CW = PW + 1;

    localparam logic [2:0] BOSTA     = 3'd0;
    localparam logic [2:0] YAZ       = 3'd1;
    localparam logic [2:0] OKU_ISTEK = 3'd2;
    localparam logic [2:0] OKU_BEKLE = 3'd3;
    localparam logic [2:0] YANIT     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [26:0]   adr_q  [DERINLIK];
    logic [26:0]   adr_d  [DERINLIK];
    logic [255:0]  line_q [DERINLIK];
    logic [255:0]  line_d [DERINLIK];
    logic [255:0]  yanit_q, yanit_d;
    logic [26:0]   oku_adr_q, oku_adr_d;

    logic [26:0]   istek_satir;
    logic          yaz_eslesme;
    logic [PW-1:0] yaz_idx;
    logic          oku_isabet;
    logic [PW-1:0] oku_idx;
    logic          yaz_kabul;
    logic          oku_kabul;
    logic          push;
    logic          pop;
    logic [4:0]    adres_ofset_unused;

    assign istek_satir        = ob_istek_adres_i[31:5];
    assign adres_ofset_unused = ob_istek_adres_i[4:0];

    // Search valid entries oldest to newest; the newest match wins for reads,
    // and the in-flight head is never a coalesce target while it is on the bus
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        yaz_eslesme = 1'b0;
        yaz_idx     = '0;
        oku_isabet  = 1'b0;
        oku_idx     = '0;
        for (int k = 0; k < DERINLIK; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (adr_q[idx] == istek_satir)) begin
                oku_isabet = 1'b1;
                oku_idx    = idx;
                if (!((state_q == YAZ) && (k == 0))) begin
                    yaz_eslesme = 1'b1;
                    yaz_idx     = idx;
                end
            end
        end
    end

    // Writes need a free slot or a coalesce target; reads only start from idle
    always_comb begin
        if (ob_istek_yaz_gecerli_i) begin
            ob_istek_hazir_o = (count_q < CW'(DERINLIK)) || yaz_eslesme;
        end else begin
            ob_istek_hazir_o = (state_q == BOSTA);
        end
    end

    assign yaz_kabul = ob_istek_gecerli_i && ob_istek_yaz_gecerli_i && ob_istek_hazir_o;
    assign oku_kabul = ob_istek_gecerli_i && !ob_istek_yaz_gecerli_i && ob_istek_hazir_o;
    assign push      = yaz_kabul && !yaz_eslesme;
    assign pop       = (state_q == YAZ) && ab_istek_hazir_i;

    // Next-state for FIFO storage, pointers, occupancy and the memory-port FSM
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        yanit_d   = yanit_q;
        oku_adr_d = oku_adr_q;
        for (int i = 0; i < DERINLIK; i++) begin
            adr_d[i]  = adr_q[i];
            line_d[i] = line_q[i];
        end

        if (yaz_kabul) begin
            if (yaz_eslesme) begin
                line_d[yaz_idx] = ob_istek_veri_i;
            end else begin
                adr_d[tail_q]  = istek_satir;
                line_d[tail_q] = ob_istek_veri_i;
                tail_d         = tail_q + 1'b1;
            end
        end

        if (pop) begin
            head_d = head_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            BOSTA: begin
                if (oku_kabul) begin
                    if (oku_isabet) begin
                        yanit_d = line_q[oku_idx];
                        state_d = YANIT;
                    end else begin
                        oku_adr_d = istek_satir;
                        state_d   = OKU_ISTEK;
                    end
                end else if (count_q != '0) begin
                    state_d = YAZ;
                end
            end
            YAZ: begin
                if (ab_istek_hazir_i) begin
                    state_d = BOSTA;
                end
            end
            OKU_ISTEK: begin
                if (ab_istek_hazir_i) begin
                    state_d = OKU_BEKLE;
                end
            end
            OKU_BEKLE: begin
                if (ab_yanit_gecerli_i) begin
                    yanit_d = ab_yanit_veri_i;
                    state_d = YANIT;
                end
            end
            YANIT: begin
                if (ob_yanit_hazir_i) begin
                    state_d = BOSTA;
                end
            end
            default: state_d = BOSTA;
        endcase
    end

    // State registers; reset discards every buffered line and any open transaction
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= BOSTA;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            yanit_q   <= '0;
            oku_adr_q <= '0;
            for (int i = 0; i < DERINLIK; i++) begin
                adr_q[i]  <= '0;
                line_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            yanit_q   <= yanit_d;
            oku_adr_q <= oku_adr_d;
            for (int i = 0; i < DERINLIK; i++) begin
                adr_q[i]  <= adr_d[i];
                line_q[i] <= line_d[i];
            end
        end
    end

    // Memory-side request: the head line while draining, the latched address while reading
    always_comb begin
        ab_istek_adres_o       = '0;
        ab_istek_veri_o        = '0;
        ab_istek_gecerli_o     = 1'b0;
        ab_istek_yaz_gecerli_o = 1'b0;
        if (state_q == YAZ) begin
            ab_istek_adres_o       = {adr_q[head_q], 5'b0};
            ab_istek_veri_o        = line_q[head_q];
            ab_istek_gecerli_o     = 1'b1;
            ab_istek_yaz_gecerli_o = 1'b1;
        end else if (state_q == OKU_ISTEK) begin
            ab_istek_adres_o   = {oku_adr_q, 5'b0};
            ab_istek_gecerli_o = 1'b1;
        end
    end

    assign ab_yanit_hazir_o   = (state_q == OKU_BEKLE);
    assign ob_yanit_gecerli_o = (state_q == YANIT);
    assign ob_yanit_veri_o    = (state_q == YANIT) ? yanit_q : '0;
    assign doluluk_o          = count_q;

endmodule

// File: tb/tb_yazma_tamponu.sv
// Directed self-checking bench for the write-back buffer.
module tb_yazma_tamponu;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  ob_istek_adres_i;
    logic [255:0] ob_istek_veri_i;
    logic         ob_istek_gecerli_i;
    logic         ob_istek_yaz_gecerli_i;
    logic         ob_istek_hazir_o;
    logic [255:0] ob_yanit_veri_o;
    logic         ob_yanit_gecerli_o;
    logic         ob_yanit_hazir_i;
    logic [31:0]  ab_istek_adres_o;
    logic [255:0] ab_istek_veri_o;
    logic         ab_istek_gecerli_o;
    logic         ab_istek_yaz_gecerli_o;
    logic         ab_istek_hazir_i;
    logic [255:0] ab_yanit_veri_i;
    logic         ab_yanit_gecerli_i;
    logic         ab_yanit_hazir_o;
    logic [2:0]   doluluk_o;

    logic         abHazir = 1'b0;
    logic         toggleEn = 1'b0;
    logic         togglePhase = 1'b0;

    int           checksTotal = 0;
    int           checksPassed = 0;
    logic [31:0]  wrAdr [$];
    logic [255:0] wrVeri [$];
    int           rdReqCycles = 0;

    yazma_tamponu #(.DERINLIK(4)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .ob_istek_adres_i       (ob_istek_adres_i),
        .ob_istek_veri_i        (ob_istek_veri_i),
        .ob_istek_gecerli_i     (ob_istek_gecerli_i),
        .ob_istek_yaz_gecerli_i (ob_istek_yaz_gecerli_i),
        .ob_istek_hazir_o       (ob_istek_hazir_o),
        .ob_yanit_veri_o        (ob_yanit_veri_o),
        .ob_yanit_gecerli_o     (ob_yanit_gecerli_o),
        .ob_yanit_hazir_i       (ob_yanit_hazir_i),
        .ab_istek_adres_o       (ab_istek_adres_o),
        .ab_istek_veri_o        (ab_istek_veri_o),
        .ab_istek_gecerli_o     (ab_istek_gecerli_o),
        .ab_istek_yaz_gecerli_o (ab_istek_yaz_gecerli_o),
        .ab_istek_hazir_i       (ab_istek_hazir_i),
        .ab_yanit_veri_i        (ab_yanit_veri_i),
        .ab_yanit_gecerli_i     (ab_yanit_gecerli_i),
        .ab_yanit_hazir_o       (ab_yanit_hazir_o),
        .doluluk_o              (doluluk_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory ready is either a fixed level or a per-cycle toggle
    always @(negedge clk_i) togglePhase = ~togglePhase;
    assign ab_istek_hazir_i = toggleEn ? togglePhase : abHazir;

    // Record every memory write handshake and every cycle a memory read is requested
    always @(posedge clk_i) begin
        if (rst_i && ab_istek_gecerli_o) begin
            if (ab_istek_yaz_gecerli_o) begin
                if (ab_istek_hazir_i) begin
                    wrAdr.push_back(ab_istek_adres_o);
                    wrVeri.push_back(ab_istek_veri_o);
                end
            end else begin
                rdReqCycles++;
            end
        end
    end

    function automatic logic [255:0] mkLine(input logic [31:0] seed);
        return {8{seed}};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checksTotal++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            checksPassed++;
        end
    endtask

    // Present one cache request and hold it until accepted or the budget runs out
    task automatic applyStimulus(input logic yaz, input logic [31:0] adr, input logic [255:0] veri, output bit ok);
        logic accepted;
        ok = 1'b0;
        ob_istek_gecerli_i     = 1'b1;
        ob_istek_yaz_gecerli_i = yaz;
        ob_istek_adres_i       = adr;
        ob_istek_veri_i        = veri;
        for (int i = 0; i < 50; i++) begin
            #1;
            accepted = ob_istek_hazir_o;
            @(posedge clk_i);
            #1;
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        ob_istek_gecerli_i = 1'b0;
        ob_istek_yaz_gecerli_i = 1'b0;
    endtask

    task automatic waitEmpty(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (doluluk_o == 3'd0 && !ab_istek_gecerli_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        bit ok;
        int base;
        logic [31:0] expAdr [4];
        logic [255:0] expVeri [4];

        rst_i = 1'b0;
        ob_istek_adres_i = '0;
        ob_istek_veri_i = '0;
        ob_istek_gecerli_i = 1'b0;
        ob_istek_yaz_gecerli_i = 1'b0;
        ob_yanit_hazir_i = 1'b0;
        ab_yanit_veri_i = '0;
        ab_yanit_gecerli_i = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_doluluk", doluluk_o, 0);
        checkOutput("rst_ab_gecerli", ab_istek_gecerli_o, 0);
        checkOutput("rst_ob_gecerli", ob_yanit_gecerli_o, 0);
        checkOutput("rst_ab_yanit_hazir", ab_yanit_hazir_o, 0);
        checkOutput("rst_ob_hazir_read", ob_istek_hazir_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Single write drained with memory always ready
        $display("[TB] test 1: single write drain");
        abHazir = 1'b1;
        applyStimulus(1'b1, 32'h100, mkLine(32'hD0D0_0000), ok);
        checkOutput("t1_accept", ok, 1);
        checkOutput("t1_doluluk1", doluluk_o, 1);
        @(posedge clk_i);
        #1;
        checkOutput("t1_ab_gecerli", ab_istek_gecerli_o, 1);
        checkOutput("t1_ab_yaz", ab_istek_yaz_gecerli_o, 1);
        checkOutput("t1_ab_adres", ab_istek_adres_o, 32'h100);
        checkOutput("t1_ab_veri", ab_istek_veri_o, mkLine(32'hD0D0_0000));
        checkOutput("t1_doluluk_inflight", doluluk_o, 1);
        @(posedge clk_i);
        #1;
        checkOutput("t1_doluluk0", doluluk_o, 0);
        checkOutput("t1_ab_idle", ab_istek_gecerli_o, 0);

        // Fill to capacity, stall a new line, coalesce into a buffered one
        $display("[TB] test 2: full buffer and coalesce");
        abHazir = 1'b0;
        base = wrAdr.size();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i * 32), mkLine(32'hA000_0000 + 32'(i)), ok);
            checkOutput("t2_fill_accept", ok, 1);
        end
        checkOutput("t2_doluluk_full", doluluk_o, 4);
        ob_istek_gecerli_i = 1'b1;
        ob_istek_yaz_gecerli_i = 1'b1;
        ob_istek_adres_i = 32'h080;
        ob_istek_veri_i = mkLine(32'hBAD0_0000);
        #1;
        checkOutput("t2_full_hazir", ob_istek_hazir_o, 0);
        ob_istek_adres_i = 32'h000;
        #1;
        checkOutput("t2_head_inflight_hazir", ob_istek_hazir_o, 0);
        ob_istek_gecerli_i = 1'b0;
        applyStimulus(1'b1, 32'h020, mkLine(32'hDDDD_0020), ok);
        checkOutput("t2_coalesce_accept", ok, 1);
        checkOutput("t2_doluluk_kept", doluluk_o, 4);
        abHazir = 1'b1;
        waitEmpty(ok);
        checkOutput("t2_drain_done", ok, 1);
        expAdr  = '{32'h000, 32'h020, 32'h040, 32'h060};
        expVeri = '{mkLine(32'hA000_0000), mkLine(32'hDDDD_0020),
                    mkLine(32'hA000_0002), mkLine(32'hA000_0003)};
        checkOutput("t2_drain_count", wrAdr.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < wrAdr.size()) begin
                checkOutput("t2_drain_adres", wrAdr[base + i], expAdr[i]);
                checkOutput("t2_drain_veri", wrVeri[base + i], expVeri[i]);
            end
        end

        // Read hit served from the buffer, memory never sees a read
        $display("[TB] test 3: read hit");
        abHazir = 1'b0;
        base = rdReqCycles;
        applyStimulus(1'b1, 32'h200, mkLine(32'hD1D1_0001), ok);
        checkOutput("t3_write_accept", ok, 1);
        applyStimulus(1'b0, 32'h204, '0, ok);
        checkOutput("t3_read_accept", ok, 1);
        checkOutput("t3_ob_gecerli", ob_yanit_gecerli_o, 1);
        checkOutput("t3_ob_veri", ob_yanit_veri_o, mkLine(32'hD1D1_0001));
        ob_yanit_hazir_i = 1'b1;
        @(posedge clk_i);
        #1;
        ob_yanit_hazir_i = 1'b0;
        checkOutput("t3_ob_released", ob_yanit_gecerli_o, 0);
        abHazir = 1'b1;
        waitEmpty(ok);
        checkOutput("t3_drain_done", ok, 1);
        checkOutput("t3_no_mem_read", rdReqCycles - base, 0);
        checkOutput("t3_drain_adres", wrAdr[wrAdr.size() - 1], 32'h200);

        // Read miss forwarded to memory, response held while cache stalls
        $display("[TB] test 4: read miss");
        abHazir = 1'b0;
        applyStimulus(1'b0, 32'h300, '0, ok);
        checkOutput("t4_read_accept", ok, 1);
        checkOutput("t4_ab_gecerli", ab_istek_gecerli_o, 1);
        checkOutput("t4_ab_yaz", ab_istek_yaz_gecerli_o, 0);
        checkOutput("t4_ab_adres", ab_istek_adres_o, 32'h300);
        checkOutput("t4_read_busy_hazir", ob_istek_hazir_o, 0);
        abHazir = 1'b1;
        @(posedge clk_i);
        #1;
        abHazir = 1'b0;
        checkOutput("t4_ab_yanit_hazir", ab_yanit_hazir_o, 1);
        checkOutput("t4_ab_req_dropped", ab_istek_gecerli_o, 0);
        ab_yanit_gecerli_i = 1'b1;
        ab_yanit_veri_i = mkLine(32'hD2D2_0002);
        @(posedge clk_i);
        #1;
        ab_yanit_gecerli_i = 1'b0;
        ab_yanit_veri_i = '0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4_hold_gecerli", ob_yanit_gecerli_o, 1);
            checkOutput("t4_hold_veri", ob_yanit_veri_o, mkLine(32'hD2D2_0002));
            @(posedge clk_i);
            #1;
        end
        ob_yanit_hazir_i = 1'b1;
        @(posedge clk_i);
        #1;
        ob_yanit_hazir_i = 1'b0;
        checkOutput("t4_ob_released", ob_yanit_gecerli_o, 0);

        // Back-to-back writes with a toggling memory ready keep their order
        $display("[TB] test 5: ordering under toggling ready");
        base = wrAdr.size();
        toggleEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(i * 32), mkLine(32'hB000_0000 + 32'(i)), ok);
            checkOutput("t5_accept", ok, 1);
        end
        waitEmpty(ok);
        checkOutput("t5_drain_done", ok, 1);
        toggleEn = 1'b0;
        checkOutput("t5_write_count", wrAdr.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < wrAdr.size()) begin
                checkOutput("t5_order_adres", wrAdr[base + i], 32'(i * 32));
                checkOutput("t5_order_veri", wrVeri[base + i], mkLine(32'hB000_0000 + 32'(i)));
            end
        end

        // Asynchronous reset while a drain is stalled on the memory port
        $display("[TB] test 6: reset mid-drain");
        abHazir = 1'b0;
        applyStimulus(1'b1, 32'h000, mkLine(32'hC0C0_0000), ok);
        checkOutput("t6_accept", ok, 1);
        @(posedge clk_i);
        #1;
        checkOutput("t6_in_yaz", ab_istek_gecerli_o, 1);
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("t6_async_gecerli", ab_istek_gecerli_o, 0);
        checkOutput("t6_async_doluluk", doluluk_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("t6_post_idle", ab_istek_gecerli_o, 0);
        applyStimulus(1'b0, 32'h000, '0, ok);
        checkOutput("t6_read_accept", ok, 1);
        checkOutput("t6_read_to_mem", ab_istek_gecerli_o, 1);
        checkOutput("t6_read_yaz", ab_istek_yaz_gecerli_o, 0);
        checkOutput("t6_read_adres", ab_istek_adres_o, 32'h000);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
